// File: rtl/wb_pkg.sv
// Shared types and constants for the write-back commit queue.
// Entry layout is fixed here so queue and scoreboard agree on field widths.
package wb_pkg;

   localparam int unsigned XLEN     = 64;
   localparam int unsigned REG_AW   = 5;
   localparam int unsigned NUM_REGS = 32;

   typedef struct packed {
      logic              wen;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
      logic [XLEN-1:0]   pc;
   } wb_entry_t;

   // x0 is hardwired, so an entry only really writes when rd is nonzero.
   function automatic logic writes_reg(input wb_entry_t e);
      return e.wen && (e.rd != '0);
   endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Per-register pending-write counters for the write-back queue.
// busy[i] is set while at least one queued entry targets xi; x0 is never busy.
module wb_scoreboard
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                inc,
   input  logic [REG_AW-1:0]   inc_rd,
   input  logic                dec,
   input  logic [REG_AW-1:0]   dec_rd,
   output logic [NUM_REGS-1:0] busy
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;

   logic [CW-1:0] cnt_q [1:NUM_REGS-1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
      end else if (clear) begin
         for (int i = 1; i < NUM_REGS; i++) begin
            cnt_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            // Simultaneous inc and dec of the same register cancel out.
            if (inc && (inc_rd == REG_AW'(i)) && !(dec && (dec_rd == REG_AW'(i)))) begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end else if (dec && (dec_rd == REG_AW'(i)) && !(inc && (inc_rd == REG_AW'(i)))) begin
               cnt_q[i] <= cnt_q[i] - 1'b1;
            end
         end
      end
   end

   always_comb begin
      busy    = '0;
      for (int i = 1; i < NUM_REGS; i++) begin
         busy[i] = (cnt_q[i] != '0);
      end
   end

endmodule

// File: rtl/wb_commit_queue.sv
// In-order write-back queue feeding the GPR write port, with pending scoreboard.
// Define WB_FWD_EN to build the youngest-entry forwarding lookup; otherwise it is tied off.
module wb_commit_queue
   import wb_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [REG_AW-1:0]        in_rd,
   input  logic                     in_wen,
   input  logic [XLEN-1:0]          in_data,
   input  logic [XLEN-1:0]          in_pc,
   input  logic                     flush_i,
   input  logic                     wb_stall_i,
   output logic [REG_AW-1:0]        reg_waddr_o,
   output logic [XLEN-1:0]          reg_wdata_o,
   output logic                     reg_wen_o,
   output logic [XLEN-1:0]          inst_addr_o,
   output logic                     commit_o,
   output logic [NUM_REGS-1:0]      busy_o,
   input  logic [REG_AW-1:0]        rs1_raddr_i,
   input  logic [REG_AW-1:0]        rs2_raddr_i,
   output logic                     rs1_fwd_hit_o,
   output logic [XLEN-1:0]          rs1_fwd_data_o,
   output logic                     rs2_fwd_hit_o,
   output logic [XLEN-1:0]          rs2_fwd_data_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [AW:0] wr_ptr_q, rd_ptr_q;
   wb_entry_t   mem_q [DEPTH];
   wb_entry_t   head;
   wb_entry_t   in_entry;
   logic        full, empty, push, pop;

   assign empty    = (wr_ptr_q == rd_ptr_q);
   assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
   assign head     = mem_q[rd_ptr_q[AW-1:0]];
   assign pop      = !empty && !wb_stall_i;
   assign in_ready = !rst && !flush_i && (!full || pop);
   assign push     = in_valid && in_ready;
   assign count_o  = wr_ptr_q - rd_ptr_q;

   always_comb begin
      in_entry      = '0;
      in_entry.wen  = in_wen;
      in_entry.rd   = in_rd;
      in_entry.data = in_data;
      in_entry.pc   = in_pc;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush_i) begin
         // Head may still retire this cycle through the combinational outputs.
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_entry;
            wr_ptr_q                <= wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
      end
   end

   always_comb begin
      commit_o    = pop;
      reg_wen_o   = pop && writes_reg(head);
      reg_waddr_o = pop ? head.rd : '0;
      reg_wdata_o = pop ? head.data : '0;
      inst_addr_o = pop ? head.pc : '0;
   end

   wb_scoreboard #(
      .DEPTH (DEPTH)
   ) u_scoreboard (
      .clk    (clk),
      .rst    (rst),
      .clear  (flush_i),
      .inc    (push && writes_reg(in_entry)),
      .inc_rd (in_rd),
      .dec    (pop && writes_reg(head)),
      .dec_rd (head.rd),
      .busy   (busy_o)
   );

`ifdef WB_FWD_EN
   logic [AW-1:0] fwd_idx;

   // Walk oldest to youngest so the last match (youngest) wins.
   always_comb begin
      rs1_fwd_hit_o  = 1'b0;
      rs1_fwd_data_o = '0;
      rs2_fwd_hit_o  = 1'b0;
      rs2_fwd_data_o = '0;
      fwd_idx        = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         fwd_idx = rd_ptr_q[AW-1:0] + AW'(i);
         if ((CW'(i) < count_o) && writes_reg(mem_q[fwd_idx])) begin
            if (mem_q[fwd_idx].rd == rs1_raddr_i) begin
               rs1_fwd_hit_o  = 1'b1;
               rs1_fwd_data_o = mem_q[fwd_idx].data;
            end
            if (mem_q[fwd_idx].rd == rs2_raddr_i) begin
               rs2_fwd_hit_o  = 1'b1;
               rs2_fwd_data_o = mem_q[fwd_idx].data;
            end
         end
      end
   end
`else
   logic unused_fwd_addr;

   assign unused_fwd_addr = ^{rs1_raddr_i, rs2_raddr_i};
   assign rs1_fwd_hit_o   = 1'b0;
   assign rs1_fwd_data_o  = '0;
   assign rs2_fwd_hit_o   = 1'b0;
   assign rs2_fwd_data_o  = '0;
`endif

endmodule

// File: tb/tb_wb_commit_queue.sv
// Self-checking bench for wb_commit_queue: queue-based reference model plus a
// decoupled commit monitor fed by an expected-retirement scoreboard.
module tb_wb_commit_queue;

   localparam int DEPTH = 4;

   typedef struct {
      bit        wen;
      bit [4:0]  rd;
      bit [63:0] data;
      bit [63:0] pc;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [4:0]  in_rd = '0;
   logic        in_wen = 1'b0;
   logic [63:0] in_data = '0;
   logic [63:0] in_pc = '0;
   logic        flush_i = 1'b0;
   logic        wb_stall_i = 1'b0;
   logic [4:0]  reg_waddr_o;
   logic [63:0] reg_wdata_o;
   logic        reg_wen_o;
   logic [63:0] inst_addr_o;
   logic        commit_o;
   logic [31:0] busy_o;
   logic [4:0]  rs1_raddr_i = '0;
   logic [4:0]  rs2_raddr_i = '0;
   logic        rs1_fwd_hit_o;
   logic [63:0] rs1_fwd_data_o;
   logic        rs2_fwd_hit_o;
   logic [63:0] rs2_fwd_data_o;
   logic [2:0]  count_o;

   int   checks = 0;
   int   errors = 0;
   ent_t model[$];
   ent_t exp_q[$];

   wb_commit_queue #(.DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .in_rd          (in_rd),
      .in_wen         (in_wen),
      .in_data        (in_data),
      .in_pc          (in_pc),
      .flush_i        (flush_i),
      .wb_stall_i     (wb_stall_i),
      .reg_waddr_o    (reg_waddr_o),
      .reg_wdata_o    (reg_wdata_o),
      .reg_wen_o      (reg_wen_o),
      .inst_addr_o    (inst_addr_o),
      .commit_o       (commit_o),
      .busy_o         (busy_o),
      .rs1_raddr_i    (rs1_raddr_i),
      .rs2_raddr_i    (rs2_raddr_i),
      .rs1_fwd_hit_o  (rs1_fwd_hit_o),
      .rs1_fwd_data_o (rs1_fwd_data_o),
      .rs2_fwd_hit_o  (rs2_fwd_hit_o),
      .rs2_fwd_data_o (rs2_fwd_data_o),
      .count_o        (count_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [64:0] got, input logic [64:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   function automatic bit [31:0] model_busy();
      bit [31:0] b = '0;
      foreach (model[i]) if (model[i].wen && model[i].rd != 0) b[model[i].rd] = 1'b1;
      return b;
   endfunction

   function automatic bit [64:0] model_fwd(input bit [4:0] a);
      bit en;
`ifdef WB_FWD_EN
      en = 1'b1;
`else
      en = 1'b0;
`endif
      if (en && a != 0)
         for (int i = model.size() - 1; i >= 0; i--)
            if (model[i].wen && model[i].rd == a) return {1'b1, model[i].data};
      return '0;
   endfunction

   // One clock of stimulus: drive, check combinational view, schedule retirement, update model.
   task automatic step(input bit v, input bit [4:0] rd, input bit wen, input bit [63:0] d,
                       input bit [63:0] pc, input bit fl, input bit st,
                       input bit [4:0] a1, input bit [4:0] a2);
      bit   pop_e, rdy_e;
      ent_t e;
      @(negedge clk);
      in_valid = v; in_rd = rd; in_wen = wen; in_data = d; in_pc = pc;
      flush_i = fl; wb_stall_i = st; rs1_raddr_i = a1; rs2_raddr_i = a2;
      #1;
      pop_e = (model.size() > 0) && !st;
      rdy_e = !fl && ((model.size() < DEPTH) || pop_e);
      chk("in_ready", in_ready, rdy_e);
      chk("count", count_o, model.size());
      chk("busy", busy_o, model_busy());
      chk("fwd1", {rs1_fwd_hit_o, rs1_fwd_data_o}, model_fwd(a1));
      chk("fwd2", {rs2_fwd_hit_o, rs2_fwd_data_o}, model_fwd(a2));
      if (pop_e) exp_q.push_back(model[0]);
      @(posedge clk);
      if (pop_e) void'(model.pop_front());
      if (fl) model.delete();
      else if (v && rdy_e) begin
         e.wen = wen; e.rd = rd; e.data = d; e.pc = pc;
         model.push_back(e);
      end
   endtask

   task automatic idle(input int n, input bit [4:0] a1);
      repeat (n) step(0, 0, 0, 0, 0, 0, 0, a1, 0);
   endtask

   // Monitor: an expected retirement queued this cycle must appear on the write port.
   initial begin
      ent_t e;
      forever begin
         @(negedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("commit", commit_o, 1);
            chk("wb_wen", reg_wen_o, e.wen && e.rd != 0);
            chk("wb_waddr", reg_waddr_o, e.rd);
            chk("wb_wdata", reg_wdata_o, e.data);
            chk("wb_pc", inst_addr_o, e.pc);
         end else begin
            chk("no_commit", commit_o, 0);
            chk("idle_wen", reg_wen_o, 0);
            chk("idle_wdata", reg_wdata_o, 0);
         end
      end
   end

   initial begin
      #1;
      chk("rst_ready", in_ready, 0);
      chk("rst_count", count_o, 0);
      chk("rst_busy", busy_o, 0);
      #20;
      @(negedge clk);
      rst = 1'b0;

      // Single push then drain.
      step(1, 5, 1, 64'h11, 64'h8000_0000, 0, 0, 5, 0);
      idle(2, 5);

      // Fill while stalled, reject when full, then full+pop accepts.
      for (int i = 0; i < 4; i++) step(1, 5'(i + 1), 1, 64'(i + 100), 64'(i * 4), 0, 1, 2, 4);
      step(1, 9, 1, 64'h99, 64'h40, 0, 1, 9, 1);
      step(1, 9, 1, 64'h9A, 64'h44, 0, 0, 9, 3);
      idle(6, 0);

      // Same register twice: youngest value forwarded.
      step(1, 3, 1, 64'h1, 64'h100, 0, 1, 3, 3);
      step(1, 3, 1, 64'h2, 64'h104, 0, 1, 3, 0);
      step(0, 0, 0, 0, 0, 0, 1, 3, 3);
      idle(4, 3);

      // Writes to x0 retire but never write or mark busy.
      step(1, 0, 1, 64'hFF, 64'h200, 0, 0, 0, 0);
      idle(2, 0);

      // Flush with head popping.
      for (int i = 0; i < 3; i++) step(1, 5'(i + 10), 1, 64'(i + 7), 64'(i * 8), 0, 1, 10, 12);
      step(1, 20, 1, 64'h55, 64'h300, 1, 0, 11, 12);
      idle(2, 11);

      // Async reset mid-drain.
      step(1, 6, 1, 64'hA, 64'h400, 0, 1, 6, 0);
      step(1, 7, 1, 64'hB, 64'h404, 0, 1, 7, 0);
      @(negedge clk);
      in_valid = 1'b0; wb_stall_i = 1'b0; flush_i = 1'b0;
      rst = 1'b1;
      #1;
      chk("arst_commit", commit_o, 0);
      chk("arst_wen", reg_wen_o, 0);
      chk("arst_count", count_o, 0);
      chk("arst_busy", busy_o, 0);
      chk("arst_ready", in_ready, 0);
      model.delete();
      @(negedge clk);
      rst = 1'b0;
      idle(3, 6);

      // Randomized traffic with varying stall pressure.
      for (int ph = 0; ph < 4; ph++) begin
         for (int n = 0; n < 150; n++) begin
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom_range(0, 3) != 0,
                 {$urandom(), $urandom()}, {$urandom(), $urandom()},
                 $urandom_range(0, 24) == 0, $urandom_range(0, 3) < ph,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         end
      end
      idle(8, 0);
      chk("drained", model.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
